wb_read_prefetch: RTL and testbench
===================================

Name: wb_read_prefetch

Overview:
- Wishbone pipelined (B4) line-prefetch buffer between the QSPI control FSM's Wishbone master and the NOR controller slave.
- A read miss fetches the whole aligned line of 2^LINE_LOG2 words downstream. Later sequential host reads in that line hit locally with 1-cycle latency.
- Writes pass through unbuffered and invalidate the line.

Parameters:
ADDRBITS, 26, word address width on both sides
DATABITS, 16, data word width
LINE_LOG2, 2, log2 of words per line (default 4-word line); legal 1..4

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
flush_i  in  1  invalidate buffered line
s_wb_cyc_i  in  1  upstream cycle
s_wb_stb_i  in  1  upstream strobe
s_wb_we_i  in  1  upstream write enable
s_wb_adr_i  in  ADDRBITS  upstream address
s_wb_dat_i  in  DATABITS  upstream write data
s_wb_dat_o  out  DATABITS  upstream read data
s_wb_ack_o  out  1  upstream ack
s_wb_err_o  out  1  upstream error
s_wb_stall_o  out  1  upstream stall
m_wb_cyc_o, m_wb_stb_o, m_wb_we_o  out  1 each  downstream cycle/strobe/write enable
m_wb_adr_o  out  ADDRBITS  downstream address
m_wb_dat_o  out  DATABITS  downstream write data
m_wb_dat_i  in  DATABITS  downstream read data
m_wb_ack_i, m_wb_err_i, m_wb_stall_i  in  1 each  downstream ack/err/stall

Behaviour:
- Reset (rst_ni low, async): all outputs 0, state IDLE, all valid bits 0, tag 0.
- Storage: tag = adr[ADDRBITS-1:LINE_LOG2]; DEPTH data words; per-word valid bits.
- Request accepted when s_cyc & s_stb & !s_stall_o. Exactly one upstream request is outstanding at a time.
- s_stall_o = 1 whenever state != IDLE or an upstream ack/err is pending.
- IDLE, read hit (tag match, valid[word]):
  - s_ack_o=1 next cycle with the stored word on s_dat_o.
  - No downstream activity.
- IDLE, read miss -> FILL:
  - Clear valid bits, load tag.
  - Next cycle m_cyc=1, m_stb=1, m_we=0, m_adr = line base.
  - Issue addresses base..base+DEPTH-1 in order, pipelined. The address advances only when m_stb & !m_stall.
  - m_stb drops after DEPTH issues; m_cyc stays high until DEPTH acks are received.
  - Each m_ack writes m_dat_i into the next fill slot (ack order = issue order) and sets its valid bit.
  - The cycle after the requested word is stored: s_ack_o=1 with that word (this may precede fill completion).
  - After the last ack: m_cyc=0, go to IDLE.
- FILL, m_err_i:
  - Drop m_cyc/m_stb next cycle and clear all valid bits; go to IDLE.
  - If the requested word was not yet acked upstream, s_err_o=1 for one cycle; otherwise no upstream response.
- IDLE, write -> WRITE:
  - Clear all valid bits.
  - Issue a single m_cyc/m_stb/m_we=1 with adr/dat copied, held until !m_stall. Then m_stb=0, m_cyc held until ack/err.
  - Next cycle s_ack_o or s_err_o mirrors the result; go to IDLE.
- s_cyc_i dropped mid-FILL:
  - The fill completes normally and the line stays valid.
  - The pending upstream ack is suppressed.
- s_cyc_i dropped mid-WRITE: the downstream write completes and no upstream response is given.
- flush_i:
  - In IDLE: clear valid bits next cycle.
  - In FILL: the line is marked invalid at completion. The requested word is still returned upstream.
- s_ack_o/s_err_o are single-cycle pulses and never both high. m_stb is never high without m_cyc.
- Top line, adr all-ones: aligned fetch, no address wrap past line end.

Test Plan:
- Read 0x000005 with the downstream slave at 2-cycle ack latency and no stall -> 4 m_stb at 0x4,0x5,0x6,0x7. Upstream ack carries the 0x5 data. Then reads 0x4, 0x6, 0x7 each ack 1 cycle after acceptance with 0 further m_stb.
- Read 0x100 with m_stall high 3 cycles on the 2nd beat -> m_adr holds 0x101 for 3 cycles. Exactly 4 downstream acks, and m_cyc falls the cycle after the 4th.
- Fill line 0x10, write 0x11=0xBEEF, then read 0x11 -> single downstream write, then a full refill of 0x10..0x13. Upstream returns 0xBEEF from the slave model.
- m_err on the 2nd beat during a read of 0x203 -> s_err_o pulses once, m_cyc drops next cycle, and a re-read of 0x200 misses (new fill).
- Fill line 0x30; assert flush_i in IDLE; read 0x31 -> refetch. Also assert rst_ni low mid-FILL -> all outputs 0 immediately and the next read misses.
- Drop s_cyc after accepting a read miss of 0x40 -> no s_ack_o. The fill completes, and a later read of 0x42 hits with 0 m_stb.

Source files
------------

// File: rtl/wb_read_prefetch.sv
// Single-line read prefetch buffer between a Wishbone B4 pipelined master and slave.
// Read misses fetch the whole aligned line; writes pass straight through and invalidate it.
module wb_read_prefetch #(
  parameter int ADDRBITS  = 26,
  parameter int DATABITS  = 16,
  parameter int LINE_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                s_wb_cyc_i,
  input  logic                s_wb_stb_i,
  input  logic                s_wb_we_i,
  input  logic [ADDRBITS-1:0] s_wb_adr_i,
  input  logic [DATABITS-1:0] s_wb_dat_i,
  output logic [DATABITS-1:0] s_wb_dat_o,
  output logic                s_wb_ack_o,
  output logic                s_wb_err_o,
  output logic                s_wb_stall_o,
  output logic                m_wb_cyc_o,
  output logic                m_wb_stb_o,
  output logic                m_wb_we_o,
  output logic [ADDRBITS-1:0] m_wb_adr_o,
  output logic [DATABITS-1:0] m_wb_dat_o,
  input  logic [DATABITS-1:0] m_wb_dat_i,
  input  logic                m_wb_ack_i,
  input  logic                m_wb_err_i,
  input  logic                m_wb_stall_i
);
  localparam int DEPTH = 1 << LINE_LOG2;
  localparam int TAGW  = ADDRBITS - LINE_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WRITE} state_t;

  state_t               r_state;
  logic [TAGW-1:0]      r_tag;
  logic [DEPTH-1:0]     r_valid;
  logic [DATABITS-1:0]  r_data [DEPTH];
  logic [LINE_LOG2-1:0] r_req_word;
  logic [LINE_LOG2-1:0] r_ack_cnt;
  logic                 r_pending;
  logic                 r_flush_pend;
  logic                 r_s_ack;
  logic                 r_s_err;
  logic [DATABITS-1:0]  r_s_dat;
  logic                 r_m_cyc;
  logic                 r_m_stb;
  logic                 r_m_we;
  logic [ADDRBITS-1:0]  r_m_adr;
  logic [DATABITS-1:0]  r_m_dat;

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_hit;
  logic                 w_live;
  logic                 w_last_issue;
  logic                 w_last_ack;
  logic [TAGW-1:0]      w_req_tag;
  logic [LINE_LOG2-1:0] w_req_word;

  assign w_req_tag    = s_wb_adr_i[ADDRBITS-1:LINE_LOG2];
  assign w_req_word   = s_wb_adr_i[LINE_LOG2-1:0];
  assign w_stall      = (r_state != ST_IDLE) || r_s_ack || r_s_err;
  assign w_accept     = s_wb_cyc_i && s_wb_stb_i && !w_stall;
  assign w_hit        = (r_tag == w_req_tag) && r_valid[w_req_word];
  // An upstream response is owed only while the master still holds its cycle.
  assign w_live       = r_pending && s_wb_cyc_i;
  assign w_last_issue = (r_m_adr[LINE_LOG2-1:0] == {LINE_LOG2{1'b1}});
  assign w_last_ack   = (r_ack_cnt == {LINE_LOG2{1'b1}});

  assign s_wb_dat_o   = r_s_dat;
  assign s_wb_ack_o   = r_s_ack;
  assign s_wb_err_o   = r_s_err;
  assign s_wb_stall_o = w_stall;
  assign m_wb_cyc_o   = r_m_cyc;
  assign m_wb_stb_o   = r_m_stb;
  assign m_wb_we_o    = r_m_we;
  assign m_wb_adr_o   = r_m_adr;
  assign m_wb_dat_o   = r_m_dat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_valid      <= '0;
      r_req_word   <= '0;
      r_ack_cnt    <= '0;
      r_pending    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_s_ack      <= 1'b0;
      r_s_err      <= 1'b0;
      r_s_dat      <= '0;
      r_m_cyc      <= 1'b0;
      r_m_stb      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_adr      <= '0;
      r_m_dat      <= '0;
    end else begin
      r_s_ack <= 1'b0;
      r_s_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (flush_i) r_valid <= '0;
          if (w_accept) begin
            if (s_wb_we_i) begin
              r_valid   <= '0;
              r_m_cyc   <= 1'b1;
              r_m_stb   <= 1'b1;
              r_m_we    <= 1'b1;
              r_m_adr   <= s_wb_adr_i;
              r_m_dat   <= s_wb_dat_i;
              r_pending <= 1'b1;
              r_state   <= ST_WRITE;
            end else if (w_hit) begin
              r_s_ack <= 1'b1;
              r_s_dat <= r_data[w_req_word];
            end else begin
              r_valid      <= '0;
              r_tag        <= w_req_tag;
              r_req_word   <= w_req_word;
              r_ack_cnt    <= '0;
              r_flush_pend <= 1'b0;
              r_pending    <= 1'b1;
              r_m_cyc      <= 1'b1;
              r_m_stb      <= 1'b1;
              r_m_we       <= 1'b0;
              r_m_adr      <= {w_req_tag, {LINE_LOG2{1'b0}}};
              r_state      <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (!s_wb_cyc_i) r_pending <= 1'b0;
          // Address stops at the last word of the line, so the top line never wraps.
          if (r_m_stb && !m_wb_stall_i) begin
            if (w_last_issue) r_m_stb <= 1'b0;
            else              r_m_adr <= r_m_adr + 1'b1;
          end
          if (m_wb_err_i) begin
            r_m_cyc   <= 1'b0;
            r_m_stb   <= 1'b0;
            r_valid   <= '0;
            r_pending <= 1'b0;
            r_s_err   <= w_live;
            r_state   <= ST_IDLE;
          end else if (m_wb_ack_i) begin
            r_valid[r_ack_cnt] <= 1'b1;
            r_ack_cnt          <= r_ack_cnt + 1'b1;
            if (w_live && (r_ack_cnt == r_req_word)) begin
              r_s_ack   <= 1'b1;
              r_s_dat   <= m_wb_dat_i;
              r_pending <= 1'b0;
            end
            if (w_last_ack) begin
              r_m_cyc <= 1'b0;
              r_m_stb <= 1'b0;
              r_state <= ST_IDLE;
              if (r_flush_pend || flush_i) r_valid <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (!s_wb_cyc_i) r_pending <= 1'b0;
          if (r_m_stb && !m_wb_stall_i) r_m_stb <= 1'b0;
          if (m_wb_ack_i || m_wb_err_i) begin
            r_m_cyc   <= 1'b0;
            r_m_stb   <= 1'b0;
            r_m_we    <= 1'b0;
            r_pending <= 1'b0;
            r_s_ack   <= w_live && m_wb_ack_i;
            r_s_err   <= w_live && !m_wb_ack_i;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Line storage holds data only; the valid bits decide whether it is meaningful.
  always_ff @(posedge clk_i) begin
    if ((r_state == ST_FILL) && m_wb_ack_i && !m_wb_err_i)
      r_data[r_ack_cnt] <= m_wb_dat_i;
  end

endmodule

// File: tb/tb_wb_read_prefetch.sv
// Bench for wb_read_prefetch: directed scenarios plus randomized read/write/flush traffic
// against a line-level reference model and a pipelined downstream slave with latency/stall/error knobs.
module tb_wb_read_prefetch;
  localparam int AW    = 26;
  localparam int DW    = 16;
  localparam int LL    = 2;
  localparam int DEPTH = 1 << LL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat, s_dat_o;
  logic          s_ack, s_err, s_stall;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_o, m_dat_i;
  logic          m_ack, m_err, m_stall;

  always #5 clk = ~clk;

  wb_read_prefetch #(.ADDRBITS(AW), .DATABITS(DW), .LINE_LOG2(LL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_wb_cyc_i(s_cyc), .s_wb_stb_i(s_stb), .s_wb_we_i(s_we),
    .s_wb_adr_i(s_adr), .s_wb_dat_i(s_dat), .s_wb_dat_o(s_dat_o),
    .s_wb_ack_o(s_ack), .s_wb_err_o(s_err), .s_wb_stall_o(s_stall),
    .m_wb_cyc_o(m_cyc), .m_wb_stb_o(m_stb), .m_wb_we_o(m_we),
    .m_wb_adr_o(m_adr), .m_wb_dat_o(m_dat_o), .m_wb_dat_i(m_dat_i),
    .m_wb_ack_i(m_ack), .m_wb_err_i(m_err), .m_wb_stall_i(m_stall)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {6'd0, a} * 32'd40503 + 32'h1234;
    return t[DW-1:0] ^ t[31:16];
  endfunction

  // Downstream slave model state
  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    int            due;
  } beat_t;

  beat_t         pend_q[$];
  beat_t         seen_q[$];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];
  int lat = 1, stall_pct = 0;
  int stall_beat = -1, stall_len = 0, stall_done = 0, stall_hits = 0;
  logic [AW-1:0] stall_watch = '0;
  int err_beat = -1;
  int beats_in_txn = 0, acks_in_txn = 0, acks_at_fall = 0;
  int cyc_num = 0, last_ack_cyc = 0, fall_cyc = 0;
  logic prev_m_cyc = 1'b0;
  int up_acks = 0, up_errs = 0, both_high = 0, stb_no_cyc = 0;

  task automatic slave_step();
    beat_t b;
    cyc_num++;
    if (s_ack) up_acks++;
    if (s_err) up_errs++;
    if (s_ack && s_err) both_high++;
    if (m_stb && !m_cyc) stb_no_cyc++;
    if (prev_m_cyc && !m_cyc) begin
      fall_cyc     = cyc_num;
      acks_at_fall = acks_in_txn;
    end
    if (!m_cyc) begin
      pend_q.delete();
      beats_in_txn = 0;
      acks_in_txn  = 0;
      stall_done   = 0;
    end
    prev_m_cyc = m_cyc;

    m_stall = 1'b0;
    if (m_cyc && m_stb) begin
      if (beats_in_txn == stall_beat && stall_done < stall_len) begin
        m_stall = 1'b1;
        stall_done++;
        if (m_adr == stall_watch) stall_hits++;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        m_stall = 1'b1;
      end
    end
    if (m_cyc && m_stb && !m_stall) begin
      b = '{m_adr, m_we, m_dat_o, cyc_num + lat};
      pend_q.push_back(b);
      seen_q.push_back(b);
      beats_in_txn++;
    end

    m_ack   = 1'b0;
    m_err   = 1'b0;
    m_dat_i = '0;
    if (m_cyc && pend_q.size() > 0 && pend_q[0].due <= cyc_num) begin
      b = pend_q.pop_front();
      if (acks_in_txn == err_beat) begin
        m_err    = 1'b1;
        err_beat = -1;
      end else begin
        m_ack = 1'b1;
        if (b.we) slv_mem[b.adr] = b.dat;
        else      m_dat_i = slv_mem.exists(b.adr) ? slv_mem[b.adr] : init_word(b.adr);
      end
      acks_in_txn++;
      last_ack_cyc = cyc_num;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  // Reference model: one line, valid as a whole, plus the expected memory image
  bit            ref_valid = 1'b0;
  logic [AW-1:0] ref_base  = '0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // mode 0: normal, 1: drop cyc right after acceptance, 2: pulse flush during the fill
  task automatic host_req(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input int mode, output logic [DW-1:0] rdat, output int resp,
                          output int rlat);
    int n;
    rdat = '0; resp = 0; rlat = 0;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_dat = dat;
    n = 0;
    while (s_stall && n < 400) begin tick(); n++; end
    chk("accept_wait", 64'(n < 400), 64'd1);
    if (n >= 400) begin s_cyc = 1'b0; s_stb = 1'b0; return; end
    tick();
    s_stb = 1'b0;
    rlat  = 1;
    if (mode == 1) begin s_cyc = 1'b0; return; end
    if (mode == 2 && !s_ack && !s_err) begin
      flush = 1'b1; tick(); flush = 1'b0; rlat = 2;
    end
    while (!s_ack && !s_err && rlat < 400) begin tick(); rlat++; end
    resp  = s_ack ? 1 : (s_err ? 2 : 0);
    rdat  = s_dat_o;
    s_cyc = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_cyc || s_stall) && n < 400) begin tick(); n++; end
    chk("idle_wait", 64'(n < 400), 64'd1);
  endtask

  task automatic op_read(input logic [AW-1:0] adr, input int mode, input string tag);
    logic [AW-1:0] base;
    logic [DW-1:0] rdat;
    int resp, rlat, a0;
    bit hit;
    base = adr & ~AW'(DEPTH - 1);
    hit  = ref_valid && (ref_base == base);
    a0   = up_acks;
    seen_q.delete();
    host_req(1'b0, adr, '0, mode, rdat, resp, rlat);
    wait_idle();
    if (mode == 1) begin
      repeat (3) tick();
      chk({tag, "_noack"}, 64'(up_acks - a0), 64'd0);
    end else begin
      chk({tag, "_resp"}, 64'(resp), 64'd1);
      chk({tag, "_data"}, rdat, ref_rd(adr));
    end
    if (hit) begin
      chk({tag, "_lat"}, 64'(rlat), 64'd1);
      chk({tag, "_beats"}, 64'(seen_q.size()), 64'd0);
    end else begin
      chk({tag, "_beats"}, 64'(seen_q.size()), 64'(DEPTH));
      for (int i = 0; i < seen_q.size() && i < DEPTH; i++)
        chk({tag, "_adr"}, {seen_q[i].we, seen_q[i].adr}, {1'b0, base + AW'(i)});
    end
    ref_valid = (mode != 2);
    ref_base  = base;
  endtask

  task automatic op_write(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input string tag);
    logic [DW-1:0] rdat;
    int resp, rlat;
    ref_valid    = 1'b0;
    ref_mem[adr] = dat;
    seen_q.delete();
    host_req(1'b1, adr, dat, 0, rdat, resp, rlat);
    wait_idle();
    chk({tag, "_resp"}, 64'(resp), 64'd1);
    chk({tag, "_beats"}, 64'(seen_q.size()), 64'd1);
    if (seen_q.size() > 0)
      chk({tag, "_beat"}, {seen_q[0].we, seen_q[0].adr, seen_q[0].dat}, {1'b1, adr, dat});
  endtask

  task automatic op_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ref_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] rd_v;
  int            rs_v, rl_v, e0, sel, r;
  logic [AW-1:0] line_v, adr_v;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_adr = '0; s_dat = '0;
    m_dat_i = '0; m_ack = 1'b0; m_err = 1'b0; m_stall = 1'b0;
    repeat (3) tick();
    chk("reset_outs", {s_dat_o, s_ack, s_err, s_stall, m_cyc, m_stb, m_we, m_adr, m_dat_o}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Miss with 2-cycle slave, then hits on the rest of the line
    lat = 2; stall_pct = 0;
    op_read(26'h5, 0, "miss5");
    op_read(26'h4, 0, "hit4");
    op_read(26'h6, 0, "hit6");
    op_read(26'h7, 0, "hit7");

    // Stall the second beat for three cycles
    lat = 1; stall_beat = 1; stall_len = 3; stall_watch = 26'h101; stall_hits = 0;
    op_read(26'h100, 0, "stall");
    chk("stall_adr_hold", 64'(stall_hits), 64'd3);
    chk("stall_acks", 64'(acks_at_fall), 64'd4);
    chk("stall_cyc_fall", 64'(fall_cyc - last_ack_cyc), 64'd1);
    stall_beat = -1;

    // Write invalidates the line and refill returns the new data
    op_read(26'h10, 0, "fill10");
    op_write(26'h11, 16'hBEEF, "wr11");
    op_read(26'h11, 0, "rd11");

    // Error on the second beat before the requested word arrives
    err_beat = 1; e0 = up_errs;
    seen_q.delete();
    host_req(1'b0, 26'h203, '0, 0, rd_v, rs_v, rl_v);
    chk("err_resp", 64'(rs_v), 64'd2);
    wait_idle();
    repeat (3) tick();
    chk("err_pulses", 64'(up_errs - e0), 64'd1);
    chk("err_cyc_drop", 64'(fall_cyc - last_ack_cyc), 64'd1);
    err_beat  = -1;
    ref_valid = 1'b0;
    op_read(26'h200, 0, "err_reread");

    // Flush while idle forces a refetch
    op_read(26'h30, 0, "fill30");
    op_flush();
    op_read(26'h31, 0, "flush_reread");

    // Asynchronous reset in the middle of a fill
    lat = 3;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 26'h50;
    tick();
    s_stb = 1'b0;
    tick(); tick();
    chk("rst_pre_fill", 64'(m_cyc), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {s_dat_o, s_ack, s_err, s_stall, m_cyc, m_stb, m_we, m_adr, m_dat_o}, 64'd0);
    s_cyc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ref_valid = 1'b0;
    op_read(26'h50, 0, "rst_reread");

    // Master abandons a miss; the fill still completes and is usable
    lat = 2;
    op_read(26'h40, 1, "abort40");
    op_read(26'h42, 0, "abort_hit42");

    // Flush during a fill: word returned, line dropped afterwards
    op_read(26'h61, 2, "flushfill61");
    op_read(26'h62, 0, "flushfill_reread");

    // Top line of the address space
    op_read(26'h3FFFFFF, 0, "topline");
    op_read(26'h3FFFFFC, 0, "topline_hit");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      sel    = int'($urandom_range(3));
      line_v = (sel == 0) ? 26'h80 : (sel == 1) ? 26'h84 : (sel == 2) ? 26'h3FFFFFC : 26'h1F0;
      adr_v  = line_v + AW'($urandom_range(3));
      lat       = int'($urandom_range(3, 1));
      stall_pct = int'($urandom_range(40));
      r = int'($urandom_range(99));
      if (r < 60)      op_read(adr_v, 0, "rnd_rd");
      else if (r < 85) op_write(adr_v, DW'($urandom), "rnd_wr");
      else             op_flush();
    end

    chk("ack_err_overlap", 64'(both_high), 64'd0);
    chk("stb_without_cyc", 64'(stb_no_cyc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
